riscv_hazard_ctrl: RTL
======================

# riscv_hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. It sits beside the datapath (`dp`) and drives the per-stage stall and flush enables and the E-stage operand forwarding selects. It covers four cases:
- load-use stalls;
- taken-branch/jump flushes;
- multi-cycle data-memory waits, with a timeout watchdog;
- optional hazard performance counters.

## Interface
Parameters:
- `MAX_WAIT`, 15: maximum M-stage memory wait cycles before `mem_err`. Legal range 1..255.
- `CNT_W`, 32: performance counter width.

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  asynchronous, active-low reset
- `rs1_d`, `rs2_d`  in  5  source registers of the instruction in D
- `rs1_e`, `rs2_e`, `rd_e`  in  5  source/destination registers in E
- `rd_m`, `rd_w`  in  5  destination registers in M and W
- `reg_we_m`, `reg_we_w`  in  1  register write enables in M and W
- `res_src_e`  in  `res_src_e`  result source in E; `RES_SRC_MEM` marks a load
- `pc_src_e`  in  `pc_src_e`  PC source resolved in E; any value other than `PC_SRC_PLUS_4` means redirect
- `mem_req_m`  in  1  M-stage instruction accesses data memory
- `mem_ready_m`  in  1  data memory completes the access this cycle
- `fwd_a_e`, `fwd_b_e`  out  `fwd_src_e`  forwarding select for ALU operands A and B
- `stall_f`, `stall_d`, `stall_e`, `stall_m`  out  1  hold the stage register
- `flush_d`, `flush_e`, `flush_w`  out  1  load a bubble (NOP, all write enables 0) into the stage register
- `mem_err`  out  1  sticky memory timeout flag
- `stall_cnt`, `flush_cnt`, `wait_cnt`  out  `CNT_W`  performance counters

## Operation
Forwarding (combinational), per operand:
- Select `FWD_M` if `reg_we_m` is set, `rd_m` ≠ 0 and `rd_m` equals the operand's rs_e.
- Otherwise select `FWD_W` under the same condition using W.
- Otherwise select `FWD_NONE`.
- M has priority over W. x0 is never forwarded.

Load-use hazard:
- Condition: `res_src_e == RES_SRC_MEM`, `rd_e` ≠ 0, and `rd_e` equals `rs1_d` or `rs2_d`.
- Response: `stall_f`, `stall_d`, `flush_e`.

Redirect (`pc_src_e` ≠ `PC_SRC_PLUS_4`):
- Response: `flush_d`, `flush_e`.
- Overrides a simultaneous load-use: `stall_f`/`stall_d` are 0, because the D instruction is wrong-path.

Memory-wait FSM, states `HZ_RUN` and `HZ_MEM_WAIT`:
- `HZ_RUN` → `HZ_MEM_WAIT` when `mem_req_m` is high and `mem_ready_m` is low. The wait counter loads 1.
- In `HZ_MEM_WAIT`, the same conditions (`mem_req_m` high, `mem_ready_m` low) hold combinationally from the first cycle. While they hold:
  - `stall_f`, `stall_d`, `stall_e`, `stall_m` and `flush_w` are asserted.
  - Load-use and redirect responses are suppressed; the branch is held in E and is re-evaluated after release.
- `HZ_MEM_WAIT` → `HZ_RUN` when `mem_ready_m` goes high. That cycle carries no memory stall; normal hazard logic applies.
- Timeout: if the wait counter reaches `MAX_WAIT` with `mem_ready_m` still low, `mem_err` sets (sticky) and the FSM returns to `HZ_RUN`, releasing the pipeline.
- Once `mem_err` is set, `mem_ready_m` is ignored and `mem_req_m` no longer causes stalls.

## Timing
- Stall, flush and forwarding outputs are combinational from inputs and FSM state, valid in the same cycle. The registered state is the FSM, the wait counter, `mem_err` and the counters.
- While `rst` is low:
  - stalls are 0, `flush_d`/`flush_e`/`flush_w` are 1, forwarding selects are `FWD_NONE`;
  - FSM is `HZ_RUN`, wait counter 0, `mem_err` 0, counters 0.
- Reset asserted mid-wait aborts the wait immediately.
- Load-use costs exactly 1 bubble; a redirect costs exactly 2 bubbles.
- A memory wait of N not-ready cycles costs N stall cycles.
- The wait counter is 8 bits and saturates; it never wraps.
- Performance counters wrap at 2^`CNT_W`.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cnt` +1 on each cycle with `stall_d` high;
  - `flush_cnt` +1 on each cycle with `flush_e` high and `rst` high;
  - `wait_cnt` +1 on each cycle in `HZ_MEM_WAIT`.
- Not defined: counter logic is absent; the three ports remain and are tied to 0.

## Structure
- `riscv/hazard.svh` (shared header) contains:
  - `fwd_src_e` (`FWD_NONE`=2'd0, `FWD_M`=2'd1, `FWD_W`=2'd2);
  - `hz_state_e` (`HZ_RUN`, `HZ_MEM_WAIT`).
- `res_src_e` and `pc_src_e` come from `riscv/datapath.svh`.
- One sub-module, `hazard_perf_cnt`: three wrapping counters with increment enables, instantiated only under `HAZARD_PERF_CNT_EN`.

## Test plan
- Back-to-back ALU ops: `rd_m`=3, `reg_we_m`=1, `rs1_e`=3, and `rd_w`=3, `reg_we_w`=1 → `fwd_a_e`=`FWD_M`. Drop `reg_we_m` → `FWD_W`. Use `rd_m`=0 → never `FWD_M`.
- Load-use: `res_src_e`=`RES_SRC_MEM`, `rd_e`=4, `rs2_d`=4 → one cycle of `stall_f`/`stall_d`/`flush_e`. Next cycle with `res_src_e`=ALU → all deasserted.
- Taken beq x1,x2 (x1=x2=1): redirect in E → `flush_d`/`flush_e` for 1 cycle. sub/or never write; x3 holds 4, then 8 from `add x3,x5,x1`. Not-taken variant → no flush, x3=24.
- Simultaneous redirect and load-use → `flush_d`=1, `flush_e`=1, `stall_f`=`stall_d`=0.
- `mem_req_m`=1, `mem_ready_m` low for 3 cycles → 3 cycles of F–M stall plus `flush_w`. Release on cycle 4. With `HAZARD_PERF_CNT_EN`, `wait_cnt`=3.
- `MAX_WAIT`=4, `mem_ready_m` held low → `mem_err`=1 after 4 cycles and the pipeline releases. Asserting `rst` low clears `mem_err` and the counters asynchronously.

Source files
------------

// File: rtl/riscv_hazard_ctrl_pkg.sv
// Shared types for the 5-stage RISC-V hazard controller: forwarding selects,
// hazard FSM states and the datapath result/PC source encodings.
package riscv_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_M    = 2'd1,
    FWD_W    = 2'd2
  } fwd_src_e;

  typedef enum logic {
    HZ_RUN      = 1'b0,
    HZ_MEM_WAIT = 1'b1
  } hz_state_e;

  // Result source of the instruction in E; RES_SRC_MEM marks a load.
  typedef enum logic [1:0] {
    RES_SRC_ALU = 2'd0,
    RES_SRC_MEM = 2'd1,
    RES_SRC_PC4 = 2'd2
  } res_src_t;

  // PC source resolved in E; anything but PC_SRC_PLUS_4 is a redirect.
  typedef enum logic [1:0] {
    PC_SRC_PLUS_4 = 2'd0,
    PC_SRC_BRANCH = 2'd1,
    PC_SRC_JALR   = 2'd2
  } pc_src_t;

  localparam int WAIT_CNT_W = 8;

  // Forwarding select for one E-stage operand; M wins over W, x0 never forwards.
  function automatic fwd_src_e fwd_select(input logic [4:0] rs,
                                          input logic [4:0] rd_m, input logic we_m,
                                          input logic [4:0] rd_w, input logic we_w);
    fwd_src_e sel;
    sel = FWD_NONE;
    if (we_w && (rd_w != 5'd0) && (rd_w == rs)) sel = FWD_W;
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) sel = FWD_M;
    return sel;
  endfunction

endpackage

// File: rtl/riscv_hazard_ctrl_perf_cnt.sv
// Three free-running wrapping hazard counters with individual increment enables.
module riscv_hazard_ctrl_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_stall_inc,
  input  logic             i_flush_inc,
  input  logic             i_wait_inc,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
  output logic [CNT_W-1:0] o_wait_cnt
);

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_wait_cnt;

  // Counters wrap naturally at 2^CNT_W; active-low reset clears them at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_wait_cnt  <= '0;
    end else begin
      if (i_stall_inc) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (i_flush_inc) r_flush_cnt <= r_flush_cnt + 1'b1;
      if (i_wait_inc)  r_wait_cnt  <= r_wait_cnt + 1'b1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
  assign o_wait_cnt  = r_wait_cnt;

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, redirect
// flush and data-memory wait with a timeout watchdog.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined;
// otherwise the counter ports read as zero.
//
// Handshake with data memory: the M-stage access is pending while mem_req_m is
// high and completes in the cycle mem_ready_m is high. Every pending cycle
// holds F..M and bubbles W; the completing cycle is a normal pipeline cycle.
module riscv_hazard_ctrl
  import riscv_hazard_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic [4:0]       rd_m,
  input  logic [4:0]       rd_w,
  input  logic             reg_we_m,
  input  logic             reg_we_w,
  input  res_src_t         res_src_e,
  input  pc_src_t          pc_src_e,
  input  logic             mem_req_m,
  input  logic             mem_ready_m,
  output fwd_src_e         fwd_a_e,
  output fwd_src_e         fwd_b_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt,
  output hz_state_e        dbg_state
);

  localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_L = WAIT_CNT_W'(MAX_WAIT);

  hz_state_e             r_state;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic                  r_mem_err;

  logic                  w_mem_busy;
  logic [WAIT_CNT_W-1:0] w_wait_next;
  logic                  w_timeout;
  logic                  w_redirect;
  logic                  w_load_use;

  // Once the watchdog has fired, the memory handshake no longer stalls anything.
  assign w_mem_busy  = !r_mem_err && mem_req_m && !mem_ready_m;
  assign w_wait_next = (r_state == HZ_RUN)           ? WAIT_CNT_W'(1) :
                       (r_wait_cnt == {WAIT_CNT_W{1'b1}}) ? r_wait_cnt :
                                                        r_wait_cnt + 1'b1;
  // A wait that reaches MAX_WAIT pending cycles is abandoned this cycle.
  assign w_timeout   = w_mem_busy && (w_wait_next >= MAX_WAIT_L);
  assign w_redirect  = (pc_src_e != PC_SRC_PLUS_4);
  assign w_load_use  = (res_src_e == RES_SRC_MEM) && (rd_e != 5'd0) &&
                       ((rd_e == rs1_d) || (rd_e == rs2_d));

  // Memory-wait FSM with its saturating wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= HZ_RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else if (w_timeout) begin
      r_state    <= HZ_RUN;
      r_wait_cnt <= w_wait_next;
      r_mem_err  <= 1'b1;
    end else if (w_mem_busy) begin
      r_state    <= HZ_MEM_WAIT;
      r_wait_cnt <= w_wait_next;
    end else begin
      r_state    <= HZ_RUN;
      r_wait_cnt <= '0;
    end
  end

  // Stall/flush/forward decode; memory wait dominates, then redirect, then load-use.
  always_comb begin
    fwd_a_e = FWD_NONE;
    fwd_b_e = FWD_NONE;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (!rst) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else begin
      fwd_a_e = fwd_select(rs1_e, rd_m, reg_we_m, rd_w, reg_we_w);
      fwd_b_e = fwd_select(rs2_e, rd_m, reg_we_m, rd_w, reg_we_w);
      if (w_mem_busy) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (w_redirect) begin
        // D holds a wrong-path instruction, so a coincident load-use is moot.
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (w_load_use) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  assign mem_err   = r_mem_err;
  assign dbg_state = r_state;

`ifdef HAZARD_PERF_CNT_EN
  riscv_hazard_ctrl_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf_cnt (
    .clk         (clk),
    .rst         (rst),
    .i_stall_inc (stall_d),
    .i_flush_inc (flush_e && rst),
    .i_wait_inc  (r_state == HZ_MEM_WAIT),
    .o_stall_cnt (stall_cnt),
    .o_flush_cnt (flush_cnt),
    .o_wait_cnt  (wait_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
  assign wait_cnt  = '0;
`endif

endmodule
